// File: rtl/pattern_pkg.sv
// Shared definitions for the test-pattern generator.
//   - Mode select encodings for the pattern_gen 'mode' input.
//   - 3-bit colour indices packed as {R,G,B}, one bit per channel.
//   - barColor(): maps a colour-bar number (0..7) to its colour index.
package pattern_pkg;

  // Pattern select encodings. Values 5..7 are reserved and render black.
  localparam logic [2:0] QUAD   = 3'd0;
  localparam logic [2:0] BARS   = 3'd1;
  localparam logic [2:0] CHECK  = 3'd2;
  localparam logic [2:0] RAMP   = 3'd3;
  localparam logic [2:0] SCROLL = 3'd4;

  // Colour indices, bit order {R,G,B}
  localparam logic [2:0] C_BLACK   = 3'b000;
  localparam logic [2:0] C_BLUE    = 3'b001;
  localparam logic [2:0] C_GREEN   = 3'b010;
  localparam logic [2:0] C_CYAN    = 3'b011;
  localparam logic [2:0] C_RED     = 3'b100;
  localparam logic [2:0] C_MAGENTA = 3'b101;
  localparam logic [2:0] C_YELLOW  = 3'b110;
  localparam logic [2:0] C_WHITE   = 3'b111;

  // Classic colour-bar order from left to right
  function automatic logic [2:0] barColor(input logic [2:0] bar);
    logic [2:0] idx;
    idx = C_BLACK;
    case (bar)
      3'd0: idx = C_WHITE;
      3'd1: idx = C_YELLOW;
      3'd2: idx = C_CYAN;
      3'd3: idx = C_GREEN;
      3'd4: idx = C_MAGENTA;
      3'd5: idx = C_RED;
      3'd6: idx = C_BLUE;
      default: idx = C_BLACK;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/pattern_color_lut.sv
// Colour index expansion: turns a 3-bit {R,G,B} index into full-intensity
// or zero channels of CW bits each.
// Ports:
//   idx_i  3-bit colour index {R,G,B}
//   r_o    red channel, CW bits
//   g_o    green channel, CW bits
//   b_o    blue channel, CW bits
module pattern_color_lut #(
  parameter int CW = 4
) (
  input  logic [2:0]    idx_i,
  output logic [CW-1:0] r_o,
  output logic [CW-1:0] g_o,
  output logic [CW-1:0] b_o
);

  assign r_o = {CW{idx_i[2]}};
  assign g_o = {CW{idx_i[1]}};
  assign b_o = {CW{idx_i[0]}};

endmodule

// File: rtl/pattern_gen.sv
// Video test-pattern generator with a two-stage pixel pipeline.
// The selected pattern is latched only at frame boundaries so a frame is
// never rendered with two different patterns.
// Ports:
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   X, Y         pixel coordinates (XW bits)
//   enable       display-active qualifier for the presented pixel
//   frame_start  one-cycle frame-boundary strobe
//   mode         pattern select, latched on frame_start
//   r, g, b      colour output, CW bits each, zero while blanking
//   valid        enable delayed by two cycles
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int H       = 640,
  parameter int V       = 480,
  parameter int XW      = 12,
  parameter int CW      = 4,
  parameter int BORDER  = 4,
  parameter int SQ_LOG2 = 5,
  parameter int FW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] X,
  input  logic [XW-1:0] Y,
  input  logic          enable,
  input  logic          frame_start,
  input  logic [2:0]    mode,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          valid
);

  // Quadrant boundaries; pixels strictly inside the cross are white
  localparam logic [XW-1:0] X_LO = XW'(H/2 - BORDER);
  localparam logic [XW-1:0] X_HI = XW'(H/2 + BORDER);
  localparam logic [XW-1:0] Y_LO = XW'(V/2 - BORDER);
  localparam logic [XW-1:0] Y_HI = XW'(V/2 + BORDER);

  logic [2:0]    mode_q;
  logic [FW-1:0] frameCnt_q;

  logic [XW-1:0] s1X_q, s1Y_q;
  logic          s1En_q;
  logic [2:0]    s1Mode_q;
  logic [FW-1:0] s1Fcnt_q;

  logic [2:0]    idx_d;
  logic [CW-1:0] lutR, lutG, lutB;
  logic [CW-1:0] r_d, g_d, b_d;
  logic [CW-1:0] r_q, g_q, b_q;
  logic          valid_q;

  // Frame-level state: mode and frame counter only move on frame_start.
  // A pixel presented alongside frame_start still sees the old values
  // because stage 1 samples them at the same edge they update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= '0;
      frameCnt_q <= '0;
    end else if (frame_start) begin
      mode_q     <= mode;
      frameCnt_q <= frameCnt_q + FW'(1);
    end
  end

  // Stage 1: capture the pixel together with the frame state it belongs to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1X_q    <= '0;
      s1Y_q    <= '0;
      s1En_q   <= 1'b0;
      s1Mode_q <= '0;
      s1Fcnt_q <= '0;
    end else begin
      s1X_q    <= X;
      s1Y_q    <= Y;
      s1En_q   <= enable;
      s1Mode_q <= mode_q;
      s1Fcnt_q <= frameCnt_q;
    end
  end

  // Colour index for the stage-1 pixel. Bars use a comparator chain
  // against constant edges; the last bar absorbs everything to the right.
  always_comb begin
    logic [2:0] bar;
    logic       scrollBit;
    idx_d     = C_BLACK;
    bar       = 3'd0;
    scrollBit = 1'b0;
    case (s1Mode_q)
      QUAD: begin
        if (s1Y_q < Y_LO)
          idx_d = (s1X_q < X_LO) ? C_RED : (s1X_q > X_HI) ? C_BLUE : C_WHITE;
        else if (s1Y_q > Y_HI)
          idx_d = (s1X_q < X_LO) ? C_GREEN : (s1X_q > X_HI) ? C_BLACK : C_WHITE;
        else
          idx_d = C_WHITE;
      end
      BARS: begin
        for (int k = 1; k < 8; k++) begin
          if (s1X_q >= XW'(k * (H / 8))) bar = 3'(k);
        end
        idx_d = barColor(bar);
      end
      CHECK: begin
        idx_d = (s1X_q[SQ_LOG2] ^ s1Y_q[SQ_LOG2]) ? C_WHITE : C_BLACK;
      end
      SCROLL: begin
        // Only the square-select bit of the shifted X matters
        scrollBit = |((s1X_q + XW'(s1Fcnt_q)) & (XW'(1) << SQ_LOG2));
        idx_d     = (scrollBit ^ s1Y_q[SQ_LOG2]) ? C_WHITE : C_BLACK;
      end
      default: idx_d = C_BLACK;
    endcase
  end

  pattern_color_lut #(
    .CW(CW)
  ) uLut (
    .idx_i(idx_d),
    .r_o  (lutR),
    .g_o  (lutG),
    .b_o  (lutB)
  );

  // Stage-2 colour select: blanking wins, ramp bypasses the index LUT
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (s1En_q) begin
      if (s1Mode_q == RAMP) begin
        r_d = s1X_q[XW-1 -: CW];
        g_d = s1X_q[XW-1 -: CW];
        b_d = s1X_q[XW-1 -: CW];
      end else begin
        r_d = lutR;
        g_d = lutG;
        b_d = lutB;
      end
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      valid_q <= s1En_q;
    end
  end

  assign r     = r_q;
  assign g     = g_q;
  assign b     = b_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard testbench for pattern_gen. Every enabled pixel pushes its
// expected colour and issue cycle; a monitor pops on valid and checks
// both colour and 2-cycle latency. Blank cycles must show zero colour.
module tb_pattern_gen;

  localparam int H = 640;
  localparam int V = 480;
  localparam int XW = 12;
  localparam int CW = 4;
  localparam int BORDER = 4;
  localparam int SQ_LOG2 = 5;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [XW-1:0] X, Y;
  logic          enable, frame_start;
  logic [2:0]    mode;
  logic [CW-1:0] r, g, b;
  logic          valid;

  typedef struct {
    int          issue;
    logic [11:0] rgb;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   modelMode = 0;
  int   modelFcnt = 0;

  pattern_gen #(
    .H(H), .V(V), .XW(XW), .CW(CW), .BORDER(BORDER), .SQ_LOG2(SQ_LOG2), .FW(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .enable(enable),
    .frame_start(frame_start), .mode(mode), .r(r), .g(g), .b(b), .valid(valid)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp issued pixels
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: colour from the pattern rules using plain arithmetic
  function automatic logic [11:0] expRgb(input int md, input int fc, input int x, input int y);
    int idx;
    int k;
    int sx;
    int barTab[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    logic [3:0] v;
    idx = 0;
    case (md)
      0: begin
        if (y < V/2 - BORDER)
          idx = (x < H/2 - BORDER) ? 4 : (x > H/2 + BORDER) ? 1 : 7;
        else if (y > V/2 + BORDER)
          idx = (x < H/2 - BORDER) ? 2 : (x > H/2 + BORDER) ? 0 : 7;
        else
          idx = 7;
      end
      1: begin
        k = x / (H / 8);
        if (k > 7) k = 7;
        idx = barTab[k];
      end
      2: idx = (((x >> SQ_LOG2) ^ (y >> SQ_LOG2)) & 1) != 0 ? 7 : 0;
      3: begin
        v = 4'(x >> (XW - CW));
        return {v, v, v};
      end
      4: begin
        sx  = (x + fc) % (1 << XW);
        idx = (((sx >> SQ_LOG2) ^ (y >> SQ_LOG2)) & 1) != 0 ? 7 : 0;
      end
      default: idx = 0;
    endcase
    return {((idx & 4) != 0) ? 4'hF : 4'h0,
            ((idx & 2) != 0) ? 4'hF : 4'h0,
            ((idx & 1) != 0) ? 4'hF : 4'h0};
  endfunction

  task automatic applyStimulus(input logic [11:0] x, input logic [11:0] y,
                               input logic en, input logic fs, input logic [2:0] md);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    X = x;
    Y = y;
    enable = en;
    frame_start = fs;
    mode = md;
    if (en) begin
      e.issue = cyc;
      e.rgb   = expRgb(modelMode, modelFcnt, int'(x), int'(y));
      expQ.push_back(e);
    end
    if (fs) begin
      modelMode = int'(md);
      modelFcnt = (modelFcnt + 1) % (1 << FW);
    end
  endtask

  // Reset with busy inputs; pixels that would leave the pipeline after the
  // reset edge are dropped from the scoreboard.
  task automatic applyReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      enable = 1'b1;
      frame_start = 1'b1;
      mode = 3'd2;
      X = 12'($urandom_range(0, 4095));
      Y = 12'($urandom_range(0, 4095));
      if (i == 0) begin
        while (expQ.size() > 0 && expQ[expQ.size()-1].issue >= cyc - 1)
          void'(expQ.pop_back());
      end
    end
    modelMode = 0;
    modelFcnt = 0;
  endtask

  // Monitor: pops on valid, otherwise checks blanking and missed outputs
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid cyc=%0d got rgb=%h, expected no output", cyc, {r, g, b});
      end else begin
        monE = expQ.pop_front();
        if (monE.issue + 2 != cyc || {r, g, b} !== monE.rgb) begin
          errors++;
          $display("[TB] FAIL pixel cyc=%0d got rgb=%h at cycle %0d, expected rgb=%h at cycle %0d",
                   cyc, {r, g, b}, cyc, monE.rgb, monE.issue + 2);
        end
      end
    end else begin
      checks++;
      if ({r, g, b} !== 12'h000 || valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL blank cyc=%0d got valid=%b rgb=%h, expected valid=0 rgb=000", cyc, valid, {r, g, b});
      end
      if (expQ.size() > 0 && expQ[0].issue + 2 <= cyc) begin
        checks++;
        errors++;
        monE = expQ.pop_front();
        $display("[TB] FAIL missing cyc=%0d got valid=0, expected rgb=%h", cyc, monE.rgb);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    X = '0;
    Y = '0;
    enable = 1'b0;
    frame_start = 1'b0;
    mode = '0;

    // Reset with everything busy, then idle; mode input 2 is not latched
    applyReset(3);
    repeat (3) applyStimulus(12'd0, 12'd0, 1'b0, 1'b0, 3'd2);

    // Quadrant (mode_q still 0 after reset)
    applyStimulus(12'd10, 12'd10, 1'b1, 1'b0, 3'd2);
    applyStimulus(12'd320, 12'd10, 1'b1, 1'b0, 3'd2);
    applyStimulus(12'd325, 12'd245, 1'b1, 1'b0, 3'd2);
    applyStimulus(12'd400, 12'd10, 1'b1, 1'b0, 3'd2);
    applyStimulus(12'd10, 12'd300, 1'b1, 1'b0, 3'd2);
    applyStimulus(12'd316, 12'd236, 1'b1, 1'b0, 3'd2);
    applyStimulus(12'd315, 12'd235, 1'b1, 1'b0, 3'd2);

    // Bars sweep; the frame_start pixel itself still renders quadrant
    applyStimulus(12'd0, 12'd0, 1'b1, 1'b1, 3'd1);
    for (int x = 0; x < H; x++) applyStimulus(12'(x), 12'd0, 1'b1, 1'b0, 3'd1);

    // Mode change without frame_start must not take effect
    applyStimulus(12'd100, 12'd100, 1'b1, 1'b1, 3'd2);
    for (int i = 0; i < 10; i++) applyStimulus(12'(i * 37), 12'(i * 23), 1'b1, 1'b0, 3'd2);
    for (int i = 0; i < 10; i++) applyStimulus(12'(i * 37), 12'(i * 23), 1'b1, 1'b0, 3'd1);
    applyStimulus(12'd50, 12'd50, 1'b1, 1'b1, 3'd1);
    for (int i = 0; i < 10; i++) applyStimulus(12'(i * 61), 12'(i * 7), 1'b1, 1'b0, 3'd1);

    // Blanking toggle
    applyStimulus(12'd10, 12'd10, 1'b1, 1'b0, 3'd1);
    applyStimulus(12'd10, 12'd10, 1'b0, 1'b0, 3'd1);
    applyStimulus(12'd100, 12'd10, 1'b1, 1'b0, 3'd1);

    // Scroll across a full frame-counter wrap
    applyStimulus(12'd0, 12'd0, 1'b1, 1'b1, 3'd4);
    for (int f = 0; f < 260; f++) begin
      applyStimulus(12'd0, 12'd0, 1'b1, 1'b0, 3'd4);
      applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 479)), 1'b1, 1'b0, 3'd4);
      applyStimulus(12'd0, 12'd0, 1'b1, 1'b1, 3'd4);
    end

    // Random traffic, all modes, occasional frame boundaries
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                    3'($urandom_range(0, 7)));
    end

    // Mid-frame reset with pixels in flight
    applyStimulus(12'd0, 12'd0, 1'b1, 1'b1, 3'd2);
    for (int i = 0; i < 5; i++) applyStimulus(12'(i * 40), 12'(i * 40), 1'b1, 1'b0, 3'd2);
    applyReset(2);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
                    3'($urandom_range(0, 7)));
    end

    repeat (4) applyStimulus(12'd0, 12'd0, 1'b0, 1'b0, 3'd0);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending pixels, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter H, default 640, active pixels per line.
REQ-002 SHALL have parameter V, default 480, active lines per frame.
REQ-003 SHALL have parameter XW, default 12, width of X/Y coordinates.
REQ-004 SHALL have parameter CW, default 4, bits per colour channel.
REQ-005 SHALL have parameter BORDER, default 4, half-width of quadrant cross in pixels.
REQ-006 SHALL have parameter SQ_LOG2, default 5, log2 of checker square size.
REQ-007 SHALL have parameter FW, default 8, frame counter width.
REQ-008 SHALL have ports: clk input 1 pixel clock; rst_n input 1 reset. One clock; reset is synchronous and active-low.
REQ-009 SHALL have ports: X input XW, Y input XW, pixel coordinates; enable input 1, display-active qualifier.
REQ-010 SHALL have ports: frame_start input 1, one-cycle frame-boundary strobe; mode input 3, pattern select.
REQ-011 SHALL have ports: r, g, b output CW each, colour; valid output 1, delayed enable.

Function
REQ-012 SHALL register mode into mode_q only on cycles with frame_start=1; mode changes never take effect mid-frame.
REQ-013 SHALL increment frame_cnt (FW bits, wraps 2^FW-1 -> 0) on every frame_start=1 cycle.
REQ-014 SHALL use pre-edge mode_q/frame_cnt for a pixel presented in the same cycle as frame_start.
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers X, Y, enable, mode_q, frame_cnt and computes a 3-bit colour index or ramp value; stage 2 registers r/g/b/valid. Latency exactly 2 cycles, throughput 1 pixel/cycle.
REQ-016 SHALL drive valid = enable delayed 2 cycles; when stage-2 enable is 0, r=g=b=0 (blanking).
REQ-017 Full intensity SHALL be all CW bits set; index bits {R,G,B} expand each to all-ones or zero.
REQ-018 Mode 0 (quadrant): X<H/2-BORDER and Y<V/2-BORDER red; X>H/2+BORDER and Y<V/2-BORDER blue; X<H/2-BORDER and Y>V/2+BORDER green; X>H/2+BORDER and Y>V/2+BORDER black; otherwise white (strict comparisons).
REQ-019 Mode 1 (bars): bar k for k*(H/8) <= X < (k+1)*(H/8), k=0..6; X >= 7*(H/8) is bar 7; colours k=0..7: white, yellow, cyan, green, magenta, red, blue, black; no divider, comparator chain against constants.
REQ-020 Mode 2 (checker): white when bit SQ_LOG2 of X XOR bit SQ_LOG2 of Y is 1, else black.
REQ-021 Mode 3 (ramp): r=g=b = X bits [XW-1 : XW-CW].
REQ-022 Mode 4 (scroll): as mode 2 but using (X + frame_cnt) truncated to XW bits, so pattern moves 1 pixel/frame left.
REQ-023 Modes 5-7 SHALL output black with valid still following enable.
REQ-024 X/Y outside H/V SHALL produce no error; colour follows the mode rules above.

Reset
REQ-025 SHALL, on rising clk with rst_n=0, clear r, g, b, valid, mode_q, frame_cnt and all pipeline registers to 0, overriding frame_start and enable in that cycle.
REQ-026 SHALL, after rst_n rises, treat the pipeline as empty: valid=0 until enable has propagated 2 cycles; mode_q=0 (quadrant) until the first frame_start.
REQ-027 Reset mid-frame SHALL discard in-flight pixels; no stale colour appears after release.

Structure
REQ-028 Shared package pattern_pkg SHALL hold mode encoding constants (QUAD=0, BARS=1, CHECK=2, RAMP=3, SCROLL=4) and the 3-bit colour index constants.
REQ-029 SHALL instantiate one sub-module, pattern_color_lut: combinational 3-bit index to CW-wide r/g/b expansion, parameter CW.

Verification
REQ-030 Reset: rst_n=0 for 3 cycles with enable=1, mode=2, frame_start=1 -> r=g=b=0, valid=0, frame_cnt=0; after release mode_q=0.
REQ-031 Latency/quadrant: mode 0 latched, X=10,Y=10,enable=1 at cycle t -> r=15,g=0,b=0,valid=1 at t+2; X=320,Y=10 -> white; X=325,Y=245 -> black.
REQ-032 Bars: mode 1, sweep X=0..639 at Y=0 -> index changes exactly at X=80,160,...,560; X=79 white, X=80 yellow, X=639 black.
REQ-033 Mode timing: mode switched 2->1 mid-frame without frame_start -> checker continues; after frame_start pulse, next pixel's colour uses bars.
REQ-034 Scroll/wrap: mode 4, 256 frame_start pulses -> frame_cnt wraps to 0; at frame_cnt=32, X=0,Y=0 output white (checker bit shifted by one square).
REQ-035 Blanking: enable toggles 1,0,1 -> valid 1,0,1 two cycles later, r=g=b=0 on the valid=0 cycle.
